seg_display_scanner: RTL and testbench

SEG_DISPLAY_SCANNER -- requirements
Module: seg_display_scanner

---
 rtl/seg_display_scanner.sv | 167 ++++++++++++++++
 tb/tb_seg_display_scanner.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_scanner.sv
// Multiplexed seven-segment display scanner with a small register bank.
// One digit is driven at a time; a programmable tick advances the scan
// index and a slower blink phase gates digits selected in the blink mask.
// All outputs are active-low.
// Optional feature: define SEG_READBACK_EN to enable registered bus reads;
// without it read_data_out is tied to 0 and no read mux exists.
module seg_display_scanner #(
  parameter int DIGITS    = 8,
  parameter int CLK_DIV   = 50000,
  parameter int BLINK_DIV = 250
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              write_enable,
  input  logic              cs,
  input  logic [3:0]        address,
  input  logic [15:0]       write_data_in,
  output logic [15:0]       read_data_out,
  output logic [DIGITS-1:0] enable,
  output logic [7:0]        value
);

  localparam int TW = $clog2(CLK_DIV);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LOAD  = TW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [2:0]    LAST_IDX   = 3'(DIGITS - 1);

  logic [15:0]   data_lo;
  logic [15:0]   data_hi;
  logic [7:0]    on_mask;
  logic [7:0]    dp_mask;
  logic [7:0]    blink_mask;

  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [2:0]    scan_idx;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  logic [2:0]        idx_nxt;
  logic [BW-1:0]     blink_cnt_nxt;
  logic              phase_nxt;
  logic [31:0]       data_all;
  logic [3:0]        nibble;
  logic [6:0]        seg;
  logic [DIGITS-1:0] enable_d;

  logic wr;
  assign wr   = cs & write_enable;
  assign tick = (tick_cnt == '0);

  // Free-running tick divider: counts down and reloads on the tick cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tick_cnt <= TICK_LOAD;
    end else if (tick) begin
      tick_cnt <= TICK_LOAD;
    end else begin
      tick_cnt <= tick_cnt - 1'b1;
    end
  end

  // Register bank writes; the upper data word only exists for 8 digits.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_lo    <= '0;
      data_hi    <= '0;
      on_mask    <= '0;
      dp_mask    <= '0;
      blink_mask <= '0;
    end else if (wr) begin
      case (address)
        4'h0: data_lo <= write_data_in;
        4'h2: if (DIGITS == 8) data_hi <= write_data_in;
        4'h4: begin
          on_mask <= write_data_in[15:8];
          dp_mask <= write_data_in[7:0];
        end
        4'h6: blink_mask <= write_data_in[7:0];
        default: ;
      endcase
    end
  end

  // Next scan position, blink phase and the decoded digit for that position.
  // Register values used here are those before any write on the same edge.
  always_comb begin
    idx_nxt       = (scan_idx == LAST_IDX) ? 3'd0 : scan_idx + 3'd1;
    blink_cnt_nxt = blink_cnt + 1'b1;
    phase_nxt     = blink_phase;
    if (blink_cnt == BLINK_LAST) begin
      blink_cnt_nxt = '0;
      phase_nxt     = ~blink_phase;
    end
    data_all = {data_hi, data_lo};
    nibble   = data_all[{idx_nxt, 2'b00} +: 4];
    case (nibble)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
    enable_d = '1;
    if (on_mask[idx_nxt] && !(blink_mask[idx_nxt] && phase_nxt)) begin
      enable_d[idx_nxt] = 1'b0;
    end
  end

  // Scan state and display outputs advance only on the tick.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      scan_idx    <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      enable      <= '1;
      value       <= 8'hFF;
    end else if (tick) begin
      scan_idx    <= idx_nxt;
      blink_cnt   <= blink_cnt_nxt;
      blink_phase <= phase_nxt;
      enable      <= enable_d;
      value       <= {seg, ~dp_mask[idx_nxt]};
    end
  end

`ifdef SEG_READBACK_EN
  logic [15:0] rd_mux;

  // Read mux over the register map; unmapped offsets read as 0.
  always_comb begin
    rd_mux = '0;
    case (address)
      4'h0: rd_mux = data_lo;
      4'h2: rd_mux = data_hi;
      4'h4: rd_mux = {on_mask, dp_mask};
      4'h6: rd_mux = {8'h00, blink_mask};
      4'h8: rd_mux = {11'd0, blink_phase, 1'b0, scan_idx};
      default: rd_mux = '0;
    endcase
  end

  // Read data loads on a selected non-write cycle and holds otherwise.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      read_data_out <= '0;
    end else if (cs && !write_enable) begin
      read_data_out <= rd_mux;
    end
  end
`else
  assign read_data_out = '0;
`endif

endmodule

// File: tb/tb_seg_display_scanner.sv
// Self-checking bench for seg_display_scanner (DIGITS=8, CLK_DIV=4,
// BLINK_DIV=2). The reference model tracks elapsed cycles since reset
// release and derives scan index and blink phase arithmetically.
module tb_seg_display_scanner;

  localparam int DIGITS    = 8;
  localparam int CLK_DIV   = 4;
  localparam int BLINK_DIV = 2;

  logic        clock;
  logic        reset;
  logic        write_enable;
  logic        cs;
  logic [3:0]  address;
  logic [15:0] write_data_in;
  logic [15:0] read_data_out;
  logic [7:0]  enable;
  logic [7:0]  value;

  int n_cmp;
  int n_err;

  // Reference model state
  int          cyc;
  int          n_tick;
  bit          ticked;
  logic [3:0]  m_dig [8];
  logic [7:0]  m_on;
  logic [7:0]  m_dp;
  logic [7:0]  m_blk;
  logic [15:0] m_rd;
  logic [15:0] cur_exp;
  logic [15:0] exp_q[$];

  seg_display_scanner #(
    .DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .BLINK_DIV(BLINK_DIV)
  ) dut (
    .clock(clock), .reset(reset), .write_enable(write_enable), .cs(cs),
    .address(address), .write_data_in(write_data_in),
    .read_data_out(read_data_out), .enable(enable), .value(value)
  );

  // Clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d, tick %0d)", tag, got, exp, cyc, n_tick);
    end
  endtask

  function automatic logic [6:0] hex_seg(input logic [3:0] h);
    case (h)
      4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;  default: return 7'b0111000;
    endcase
  endfunction

  function automatic logic [15:0] model_read(input logic [3:0] a);
    int idx;
    int ph;
    idx = n_tick % DIGITS;
    ph  = (n_tick / BLINK_DIV) % 2;
    case (a)
      4'h0: return {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
      4'h2: return {m_dig[7], m_dig[6], m_dig[5], m_dig[4]};
      4'h4: return {m_on, m_dp};
      4'h6: return {8'h00, m_blk};
      4'h8: return 16'(idx) | (16'(ph) << 4);
      default: return 16'h0000;
    endcase
  endfunction

  task automatic model_reset();
    cyc     = 0;
    n_tick  = 0;
    ticked  = 0;
    for (int i = 0; i < 8; i++) m_dig[i] = 4'h0;
    m_on    = 8'h00;
    m_dp    = 8'h00;
    m_blk   = 8'h00;
    m_rd    = 16'h0000;
    cur_exp = 16'hFFFF;
    exp_q.delete();
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge(input logic c, input logic w, input logic [3:0] a, input logic [15:0] d);
    int i;
    int ph;
    logic [7:0] en;
`ifdef SEG_READBACK_EN
    if (c && !w) m_rd = model_read(a);
`endif
    cyc++;
    ticked = 0;
    if (cyc % CLK_DIV == 0) begin
      n_tick++;
      ticked = 1;
      i  = n_tick % DIGITS;
      ph = (n_tick / BLINK_DIV) % 2;
      en = 8'hFF;
      if (m_on[i] && !(m_blk[i] && ph == 1)) en[i] = 1'b0;
      exp_q.push_back({en, hex_seg(m_dig[i]), ~m_dp[i]});
    end
    if (c && w) begin
      case (a)
        4'h0: for (int k = 0; k < 4; k++) m_dig[k] = d[4*k +: 4];
        4'h2: for (int k = 0; k < 4; k++) m_dig[k+4] = d[4*k +: 4];
        4'h4: begin m_on = d[15:8]; m_dp = d[7:0]; end
        4'h6: m_blk = d[7:0];
        default: ;
      endcase
    end
  endtask

  // Driver: one clock with the given bus inputs, then model update and checks.
  task automatic step(input logic c, input logic w, input logic [3:0] a, input logic [15:0] d);
    cs = c; write_enable = w; address = a; write_data_in = d;
    @(posedge clock);
    model_edge(c, w, a, d);
    #1;
    if (exp_q.size() > 0) cur_exp = exp_q.pop_front();
    check("enable", {24'd0, enable}, {24'd0, cur_exp[15:8]});
    check("value", {24'd0, value}, {24'd0, cur_exp[7:0]});
    check("read_data_out", {16'd0, read_data_out}, {16'd0, m_rd});
    cs = 1'b0; write_enable = 1'b0;
  endtask

  task automatic wr_reg(input logic [3:0] a, input logic [15:0] d);
    step(1'b1, 1'b1, a, d);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'h0, 16'h0000);
  endtask

  // Idle until the tick that lands on the target index, bounded.
  task automatic run_to_idx(input int target);
    bit found;
    found = 0;
    for (int k = 0; k < 4 * CLK_DIV * DIGITS && !found; k++) begin
      idle();
      if (ticked && (n_tick % DIGITS) == target) found = 1;
    end
    if (!found) check("run_to_idx timeout", 32'd0, 32'd1);
  endtask

  function automatic logic [3:0] rand_addr();
    logic [3:0] tbl [8];
    tbl = '{4'h0, 4'h2, 4'h4, 4'h6, 4'h8, 4'hA, 4'hC, 4'h1};
    return tbl[$urandom_range(7, 0)];
  endfunction

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    cs = 1'b0; write_enable = 1'b0; address = 4'h0; write_data_in = 16'h0000;
    model_reset();

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("reset enable", {24'd0, enable}, 32'h0000_00FF);
    check("reset value", {24'd0, value}, 32'h0000_00FF);
    check("reset read", {16'd0, read_data_out}, 32'h0);
    reset = 1'b1;
    model_reset();

    // First tick lands on the fourth edge after release, index 1, all dark
    for (int k = 1; k <= 3; k++) begin
      idle();
      check("pre-tick enable", {24'd0, enable}, 32'h0000_00FF);
      check("pre-tick value", {24'd0, value}, 32'h0000_00FF);
    end
    idle();
    check("first tick value", {24'd0, value}, {24'd0, 8'b00000011});

    // Data and on-mask decode
    wr_reg(4'h0, 16'h3210);
    wr_reg(4'h4, 16'hFF00);
    run_to_idx(1);
    check("idx1 enable", {24'd0, enable}, 32'h0000_00FD);
    check("idx1 value", {24'd0, value}, {24'd0, 8'b10011111});
    run_to_idx(2);
    check("idx2 value", {24'd0, value}, {24'd0, 8'b00100101});

    // DP mask and partial on-mask
    wr_reg(4'h4, 16'h0F04);
    run_to_idx(2);
    check("idx2 dp", {31'd0, value[0]}, 32'd0);
    run_to_idx(5);
    check("idx5 dark", {24'd0, enable}, 32'h0000_00FF);

    // Blink: digit 0 visited in phase 0, digit 2 visited in phase 1
    wr_reg(4'h4, 16'hFF00);
    wr_reg(4'h6, 16'h0001);
    run_to_idx(0);
    check("blink idx0 lit", {24'd0, enable}, 32'h0000_00FE);
    wr_reg(4'h6, 16'h0004);
    run_to_idx(2);
    check("blink idx2 dark", {24'd0, enable}, 32'h0000_00FF);
    run_to_idx(1);
    check("blink idx1 lit", {24'd0, enable}, 32'h0000_00FD);

`ifdef SEG_READBACK_EN
    wr_reg(4'h2, 16'hBEEF);
    step(1'b1, 1'b0, 4'h2, 16'h0000);
    check("read 0x2", {16'd0, read_data_out}, 32'h0000_BEEF);
    step(1'b1, 1'b0, 4'hA, 16'h0000);
    check("read 0xA", {16'd0, read_data_out}, 32'h0);
`else
    wr_reg(4'h2, 16'hBEEF);
    step(1'b1, 1'b0, 4'h2, 16'h0000);
    check("no readback", {16'd0, read_data_out}, 32'h0);
`endif

    // Randomized bus traffic against the model
    for (int k = 0; k < 1500; k++) begin
      step(($urandom_range(3, 0) != 0), $urandom_range(1, 0), rand_addr(), 16'($urandom));
    end

    // Asynchronous reset in the middle of a scan
    run_to_idx(5);
    #2 reset = 1'b0;
    #1;
    check("async rst enable", {24'd0, enable}, 32'h0000_00FF);
    check("async rst value", {24'd0, value}, 32'h0000_00FF);
    check("async rst read", {16'd0, read_data_out}, 32'h0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    model_reset();
`ifdef SEG_READBACK_EN
    for (int a = 0; a <= 6; a += 2) begin
      step(1'b1, 1'b0, 4'(a), 16'h0000);
      check("post-reset reg", {16'd0, read_data_out}, 32'h0);
    end
`endif
    run_to_idx(1);
    check("restart idx1 value", {24'd0, value}, {24'd0, 8'b00000011});
    for (int k = 0; k < 200; k++) idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time bound
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
